counter_sequencer: RTL and testbench

- Command-driven controller for the 8-bit up/down counter (ports en, m, load, data_in, count).
- Accepts one job per valid/ready handshake: {start value, target value, direction}.
- Loads the counter, enables counting until count equals target, then reports completion with step count and status.
- Sits between a host/test sequencer and the counter instance; it is the only driver of the counter's control inputs.

---
 rtl/counter_sequencer.sv | 154 +++++++++++++++
 tb/tb_counter_sequencer.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/counter_sequencer.sv
// Job controller for an up/down counter: load start, count to target, report steps/status (watchdog: SEQ_TIMEOUT_EN).
// Latency: LOAD 1 cycle, RUN N+1 cycles, DONE 1 cycle; cmd_ready returns the cycle after DONE.
// Backpressure: one job in flight; cmd_ready is low from handshake until the job's DONE cycle has passed.
module counter_sequencer #(
  parameter int WIDTH          = 8,
  parameter int TIMEOUT_CYCLES = 300
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [WIDTH-1:0] cmd_start,
  input  logic [WIDTH-1:0] cmd_target,
  input  logic             cmd_dir,
  input  logic             abort,
  output logic             done_valid,
  output logic [WIDTH-1:0] done_steps,
  output logic [1:0]       done_status,
  output logic             cnt_en,
  output logic             cnt_m,
  output logic             cnt_load,
  output logic [WIDTH-1:0] cnt_data_in,
  input  logic [WIDTH-1:0] cnt_count
);

  typedef enum logic [1:0] {IDLE, LOAD, RUN, DONE} state_t;

  localparam logic [1:0] ST_OK      = 2'b00;
  localparam logic [1:0] ST_ABORT   = 2'b01;
  localparam logic [1:0] ST_TIMEOUT = 2'b10;

  if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be at least 1");
  end

  state_t           state_q, state_d;
  logic             ready_q;
  logic [WIDTH-1:0] start_q, target_q, steps_q;
  logic             dir_q;
  logic [WIDTH-1:0] done_steps_q;
  logic [1:0]       done_status_q;
  logic             finish;
  logic [1:0]       fin_status;
  logic             match;
  logic             timeout;

  assign match = (cnt_count == target_q);

`ifdef SEQ_TIMEOUT_EN
  localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [WD_W-1:0] wd_q;

  // Counts RUN cycles; held at zero outside RUN so each job starts fresh.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wd_q <= '0;
    end else if (state_q != RUN) begin
      wd_q <= '0;
    end else if (wd_q != WD_W'(TIMEOUT_CYCLES)) begin
      wd_q <= wd_q + 1'b1;
    end
  end

  assign timeout = (state_q == RUN) && (wd_q == WD_W'(TIMEOUT_CYCLES));
`else
  assign timeout = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    cmd_ready   = 1'b0;
    done_valid  = 1'b0;
    cnt_en      = 1'b0;
    cnt_m       = 1'b0;
    cnt_load    = 1'b0;
    cnt_data_in = '0;
    finish      = 1'b0;
    fin_status  = ST_OK;
    case (state_q)
      IDLE: begin
        cmd_ready = ready_q;
        if (cmd_valid && ready_q) state_d = LOAD;
      end
      LOAD: begin
        cnt_load    = 1'b1;
        cnt_data_in = start_q;
        cnt_m       = dir_q;
        if (abort) begin
          state_d    = DONE;
          finish     = 1'b1;
          fin_status = ST_ABORT;
        end else begin
          state_d = RUN;
        end
      end
      RUN: begin
        cnt_m  = dir_q;
        cnt_en = !match && !abort && !timeout;
        // Abort outranks a same-cycle match, which outranks the watchdog.
        if (abort) begin
          state_d    = DONE;
          finish     = 1'b1;
          fin_status = ST_ABORT;
        end else if (match) begin
          state_d    = DONE;
          finish     = 1'b1;
          fin_status = ST_OK;
        end else if (timeout) begin
          state_d    = DONE;
          finish     = 1'b1;
          fin_status = ST_TIMEOUT;
        end
      end
      DONE: begin
        done_valid = 1'b1;
        state_d    = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      ready_q       <= 1'b0;
      start_q       <= '0;
      target_q      <= '0;
      dir_q         <= 1'b0;
      steps_q       <= '0;
      done_steps_q  <= '0;
      done_status_q <= ST_OK;
    end else begin
      state_q <= state_d;
      ready_q <= 1'b1;
      if (state_q == IDLE && cmd_valid && ready_q) begin
        start_q  <= cmd_start;
        target_q <= cmd_target;
        dir_q    <= cmd_dir;
        steps_q  <= '0;
      end else if (cnt_en) begin
        steps_q <= steps_q + 1'b1;
      end
      // The exit cycle never has cnt_en high, so steps_q is already final here.
      if (finish) begin
        done_steps_q  <= steps_q;
        done_status_q <= fin_status;
      end
    end
  end

  assign done_steps  = done_steps_q;
  assign done_status = done_status_q;

endmodule

// File: tb/tb_counter_sequencer.sv
// Randomized scoreboard bench for counter_sequencer with a behavioural counter beside it.
module tb_counter_sequencer;

  localparam int W  = 8;
  localparam int TO = 16;
`ifdef SEQ_TIMEOUT_EN
  localparam bit TO_ON = 1'b1;
`else
  localparam bit TO_ON = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         cmd_valid = 1'b0;
  logic         cmd_ready;
  logic [W-1:0] cmd_start = '0;
  logic [W-1:0] cmd_target = '0;
  logic         cmd_dir = 1'b0;
  logic         abort = 1'b0;
  logic         done_valid;
  logic [W-1:0] done_steps;
  logic [1:0]   done_status;
  logic         cnt_en, cnt_m, cnt_load;
  logic [W-1:0] cnt_data_in;
  logic [W-1:0] cnt_count;
  logic         stuck = 1'b0;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  typedef struct {int steps; int status; int count; int cyc;} exp_t;
  typedef struct {int data; int cyc;} ld_t;
  exp_t exp_q[$];
  ld_t  ld_q[$];
  int   last_steps = 0;
  int   last_status = 0;

  counter_sequencer #(.WIDTH(W), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_start(cmd_start), .cmd_target(cmd_target), .cmd_dir(cmd_dir),
    .abort(abort),
    .done_valid(done_valid), .done_steps(done_steps), .done_status(done_status),
    .cnt_en(cnt_en), .cnt_m(cnt_m), .cnt_load(cnt_load),
    .cnt_data_in(cnt_data_in), .cnt_count(cnt_count)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Counter being controlled; 'stuck' freezes stepping to exercise the watchdog.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_count <= '0;
    else if (cnt_load) cnt_count <= cnt_data_in;
    else if (cnt_en && !stuck) cnt_count <= cnt_m ? cnt_count + 1'b1 : cnt_count - 1'b1;
  end

  task automatic chk(input string nm, input int act, input int exp_v);
    checks++;
    if (act != exp_v) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d", nm, act, exp_v);
    end
  endtask

  task automatic unexpected(input string nm);
    checks++;
    errors++;
    $display("FAIL %s actual=event expected=none", nm);
  endtask

  // Monitor: pops expectations whenever the DUT loads the counter or reports done.
  always @(negedge clk) begin
    if (rst_n) begin
      if (cnt_load) begin
        if (ld_q.size() == 0) unexpected("unexpected_load");
        else begin
          ld_t l;
          l = ld_q.pop_front();
          chk("load_data", int'(cnt_data_in), l.data);
          chk("load_cyc", cyc, l.cyc);
        end
      end
      if (done_valid) begin
        if (exp_q.size() == 0) unexpected("unexpected_done");
        else begin
          exp_t e;
          e = exp_q.pop_front();
          chk("done_steps", int'(done_steps), e.steps);
          chk("done_status", int'(done_status), e.status);
          chk("final_count", int'(cnt_count), e.count);
          chk("done_cyc", cyc, e.cyc);
          last_steps  = e.steps;
          last_status = e.status;
        end
      end
    end
  end

  // Reference: job ends at the earliest of match (RUN index n), abort (k) or watchdog (TO);
  // abort wins any tie, match beats the watchdog.
  function automatic void model(input int n, input int k, output int steps, output int st);
    steps = n;
    st    = 0;
    if (TO_ON && TO < steps) begin
      steps = TO;
      st    = 2;
    end
    if (k >= 0 && k <= steps) begin
      steps = k;
      st    = 1;
    end
  endfunction

  task automatic wait_ready(input int exp_cyc);
    int n = 0;
    while (!cmd_ready && n < 2000) begin
      @(negedge clk);
      n++;
    end
    if (!cmd_ready) begin
      $display("FAIL ready_timeout actual=0 expected=1");
      errors++;
      checks++;
    end else if (exp_cyc >= 0) begin
      chk("ready_cyc", cyc, exp_cyc);
    end
  endtask

  task automatic issue(input int s, input int t, input int d, output int h);
    cmd_start  = W'(s);
    cmd_target = W'(t);
    cmd_dir    = d[0];
    cmd_valid  = 1'b1;
    @(posedge clk);
    #1;
    h          = cyc;
    cmd_valid  = 1'b0;
    chk("ready_low_in_load", int'(cmd_ready), 0);
    // Scribble the command bus: the running job must not notice.
    cmd_start  = W'($urandom);
    cmd_target = W'($urandom);
    cmd_dir    = 1'($urandom);
  endtask

  // k: -2 no abort, -1 abort during LOAD, >=0 abort in that RUN cycle.
  task automatic run_job(input int s, input int t, input int d, input int k);
    int h, n, steps, st, cnt, dcyc;
    if (stuck) n = 100000;
    else n = d ? ((t - s) & 255) : ((s - t) & 255);
    if (k == -1) begin
      steps = 0;
      st    = 1;
    end else begin
      model(n, k, steps, st);
    end
    if (stuck) cnt = s;
    else cnt = d ? ((s + steps) & 255) : ((s - steps) & 255);
    issue(s, t, d, h);
    dcyc = (k == -1) ? h + 1 : h + 2 + steps;
    ld_q.push_back('{data: s, cyc: h});
    exp_q.push_back('{steps: steps, status: st, count: cnt, cyc: dcyc});
    if (k == -1) begin
      abort = 1'b1;
      @(posedge clk);
      #1 abort = 1'b0;
    end else if (k >= 0 && st == 1) begin
      while (cyc < h + 1 + k) begin
        @(posedge clk);
        #1;
      end
      abort = 1'b1;
      @(posedge clk);
      #1 abort = 1'b0;
    end
    @(negedge clk);
    wait_ready(dcyc + 1);
    chk("steps_retained", int'(done_steps), last_steps);
    chk("status_retained", int'(done_status), last_status);
  endtask

  initial begin
    #2000000;
    $display("FAIL global_timeout actual=running expected=finished");
    $fatal(1, "bench did not finish");
  end

  initial begin
    int h;
    repeat (3) @(negedge clk);
    chk("rst_cmd_ready", int'(cmd_ready), 0);
    chk("rst_done_valid", int'(done_valid), 0);
    chk("rst_done_steps", int'(done_steps), 0);
    chk("rst_done_status", int'(done_status), 0);
    chk("rst_cnt_en", int'(cnt_en), 0);
    chk("rst_cnt_m", int'(cnt_m), 0);
    chk("rst_cnt_load", int'(cnt_load), 0);
    chk("rst_cnt_data_in", int'(cnt_data_in), 0);
    rst_n = 1'b1;
    @(posedge clk);
    #1 chk("ready_after_reset", int'(cmd_ready), 1);
    @(negedge clk);

    run_job(10, 15, 1, -2);
    run_job(3, 250, 0, -2);
    run_job(7, 7, 1, -2);
    run_job(0, 200, 1, 20);
    run_job(250, 5, 1, -2);
    run_job(40, 60, 1, -1);
    run_job(9, 1, 0, 8);

    for (int i = 0; i < 30; i++) begin
      int s, t, d, n, k;
      s = int'($urandom_range(0, 255));
      t = int'($urandom_range(0, 255));
      d = int'($urandom_range(0, 1));
      n = d ? ((t - s) & 255) : ((s - t) & 255);
      k = -2;
      if ($urandom_range(0, 3) == 0) k = int'($urandom_range(0, n));
      else if ($urandom_range(0, 15) == 0) k = -1;
      run_job(s, t, d, k);
    end

    // Reset in the middle of RUN: outputs drop at once and no done is reported.
    issue(100, 150, 1, h);
    ld_q.push_back('{data: 100, cyc: h});
    while (cyc < h + 10) begin
      @(posedge clk);
      #1;
    end
    rst_n = 1'b0;
    #1;
    chk("midrst_outputs", int'({cmd_ready, done_valid, done_steps, done_status,
                                cnt_en, cnt_m, cnt_load, cnt_data_in}), 0);
    exp_q.delete();
    last_steps  = 0;
    last_status = 0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    wait_ready(-1);
    @(negedge clk);
    run_job(100, 150, 1, -2);

    // Frozen counter: watchdog ends the job if present, otherwise only abort does.
    stuck = 1'b1;
    run_job(4, 9, 1, 30);
    stuck = 1'b0;
    run_job(20, 10, 0, -2);

    repeat (5) @(negedge clk);
    chk("scoreboard_empty", exp_q.size(), 0);
    chk("load_queue_empty", ld_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
